// File: rtl/rob_pkg.sv
// Shared types and widths for the ROB commit path: index/physical-register/PC widths,
// the commit controller state encoding and the committed-entry record.
package rob_pkg;

    localparam int unsigned ROB_IDX_W = 8;
    localparam int unsigned PHYS_W    = 7;
    localparam int unsigned PC_W      = 64;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StStoreWait = 2'd1,
        StRecover   = 2'd2
    } commit_state_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [PHYS_W-1:0]    rd_phys;
        logic [PHYS_W-1:0]    old_phys;
        logic                 is_store;
        logic                 misp;
        logic [PC_W-1:0]      target;
    } commit_entry_t;

endpackage

// File: rtl/rob_commit_skid.sv
// One-entry holding buffer for a commit that the ROB pops during the cycle after
// commit_ready_o falls. Load and take may coincide; load wins the entry.
module rob_commit_skid
    import rob_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  commit_entry_t entry_i,
    input  logic          take_i,
    output logic          valid_o,
    output commit_entry_t entry_o
);

    logic          valid_q, valid_d;
    commit_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = load_i | (valid_q & ~take_i);
        entry_d = load_i ? entry_i : entry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit controller: frees old physical registers, releases stores to the LSU, and
// turns mispredicts into flush/redirect plus a RECOVER stall. ROB_COMMIT_PERF_EN adds counters.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned RECOVER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 commit_valid_i,
    input  logic [ROB_IDX_W-1:0] commit_idx_i,
    input  logic [PHYS_W-1:0]    commit_rd_phys_i,
    input  logic [PHYS_W-1:0]    commit_old_phys_i,
    input  logic                 commit_is_store_i,
    input  logic                 commit_branch_misp_i,
    input  logic [PC_W-1:0]      commit_branch_target_i,
    output logic                 commit_ready_o,
    output logic                 free_valid_o,
    output logic [PHYS_W-1:0]    free_phys_o,
    output logic                 store_commit_valid_o,
    output logic [ROB_IDX_W-1:0] store_commit_idx_o,
    input  logic                 store_commit_ready_i,
    output logic                 flush_o,
    output logic                 redirect_valid_o,
    output logic [PC_W-1:0]      redirect_pc_o,
    output logic                 alloc_stall_o
`ifdef ROB_COMMIT_PERF_EN
    ,
    output logic [31:0]          perf_commits_o,
    output logic [31:0]          perf_flushes_o,
    output logic [31:0]          perf_squashed_o
`endif
);

    localparam int unsigned CntW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(RECOVER_CYCLES - 1);

    commit_state_t        state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 misp_q, misp_d;
    logic [PC_W-1:0]      tgt_q, tgt_d;
    logic                 free_valid_q, free_valid_d;
    logic [PHYS_W-1:0]    free_phys_q, free_phys_d;
    logic                 store_valid_q, store_valid_d;
    logic [ROB_IDX_W-1:0] store_idx_q, store_idx_d;
    logic                 flush_q, flush_d;
    logic                 redir_valid_q, redir_valid_d;
    logic [PC_W-1:0]      redir_pc_q, redir_pc_d;

    commit_entry_t in_entry, skid_entry, proc_entry, drop_entry;
    logic          skid_valid, skid_load, skid_take;
    logic          proc_valid, drop_valid, flush_req;
    logic [PC_W-1:0] flush_pc;

    always_comb begin
        in_entry.idx      = commit_idx_i;
        in_entry.rd_phys  = commit_rd_phys_i;
        in_entry.old_phys = commit_old_phys_i;
        in_entry.is_store = commit_is_store_i;
        in_entry.misp     = commit_branch_misp_i;
        in_entry.target   = commit_branch_target_i;
    end

    rob_commit_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .entry_i (in_entry),
        .take_i  (skid_take),
        .valid_o (skid_valid),
        .entry_o (skid_entry)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        misp_d        = misp_q;
        tgt_d         = tgt_q;
        free_valid_d  = 1'b0;
        free_phys_d   = free_phys_q;
        store_valid_d = store_valid_q;
        store_idx_d   = store_idx_q;
        flush_d       = 1'b0;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        skid_load     = 1'b0;
        skid_take     = 1'b0;
        proc_valid    = 1'b0;
        proc_entry    = in_entry;
        drop_valid    = 1'b0;
        drop_entry    = in_entry;
        flush_req     = 1'b0;
        flush_pc      = tgt_q;

        unique case (state_q)
            StRun: begin
                // A buffered entry is older than anything arriving now, so it goes first.
                if (skid_valid) begin
                    proc_valid = 1'b1;
                    proc_entry = skid_entry;
                    skid_take  = 1'b1;
                    skid_load  = commit_valid_i;
                end else if (commit_valid_i) begin
                    proc_valid = 1'b1;
                end
            end
            StStoreWait: begin
                skid_load = commit_valid_i;
                if (store_commit_ready_i) begin
                    store_valid_d = 1'b0;
                    if (misp_q) begin
                        misp_d    = 1'b0;
                        flush_req = 1'b1;
                        flush_pc  = tgt_q;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRecover: begin
                if (skid_valid) begin
                    drop_valid = 1'b1;
                    drop_entry = skid_entry;
                    skid_take  = 1'b1;
                    skid_load  = commit_valid_i;
                end else if (commit_valid_i) begin
                    drop_valid = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StRun;
        endcase

        if (proc_valid) begin
            if (proc_entry.old_phys != '0) begin
                free_valid_d = 1'b1;
                free_phys_d  = proc_entry.old_phys;
            end
            if (proc_entry.is_store) begin
                // A mispredicted store defers its flush until the LSU accepts the release.
                store_valid_d = 1'b1;
                store_idx_d   = proc_entry.idx;
                misp_d        = proc_entry.misp;
                tgt_d         = proc_entry.target;
                state_d       = StStoreWait;
            end else if (proc_entry.misp) begin
                flush_req = 1'b1;
                flush_pc  = proc_entry.target;
            end
        end

        // Wrong-path entry: its new destination was never architecturally visible.
        if (drop_valid && (drop_entry.rd_phys != '0)) begin
            free_valid_d = 1'b1;
            free_phys_d  = drop_entry.rd_phys;
        end

        if (flush_req) begin
            flush_d       = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = flush_pc;
            state_d       = (RECOVER_CYCLES == 0) ? StRun : StRecover;
            cnt_d         = CntInit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            misp_q        <= 1'b0;
            tgt_q         <= '0;
            free_valid_q  <= 1'b0;
            free_phys_q   <= '0;
            store_valid_q <= 1'b0;
            store_idx_q   <= '0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            misp_q        <= misp_d;
            tgt_q         <= tgt_d;
            free_valid_q  <= free_valid_d;
            free_phys_q   <= free_phys_d;
            store_valid_q <= store_valid_d;
            store_idx_q   <= store_idx_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign commit_ready_o       = (state_q == StRun) && !skid_valid;
    assign free_valid_o         = free_valid_q;
    assign free_phys_o          = free_phys_q;
    assign store_commit_valid_o = store_valid_q;
    assign store_commit_idx_o   = store_idx_q;
    assign flush_o              = flush_q;
    assign redirect_valid_o     = redir_valid_q;
    assign redirect_pc_o        = redir_pc_q;
    assign alloc_stall_o        = (state_q == StRecover);

`ifdef ROB_COMMIT_PERF_EN
    logic [31:0] perf_commits_q, perf_commits_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_commits_d  = perf_commits_q + {31'd0, proc_valid};
        perf_flushes_d  = perf_flushes_q + {31'd0, flush_req};
        perf_squashed_d = perf_squashed_q + {31'd0, drop_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commits_q  <= '0;
            perf_flushes_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_commits_q  <= perf_commits_d;
            perf_flushes_q  <= perf_flushes_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_commits_o  = perf_commits_q;
    assign perf_flushes_o  = perf_flushes_q;
    assign perf_squashed_o = perf_squashed_q;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl: directed commits push expected frees, store releases,
// flushes and stall lengths; a negedge monitor pops and compares them as the DUT emits them.
module tb_rob_commit_ctrl;
    import rob_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 commit_valid_i;
    logic [ROB_IDX_W-1:0] commit_idx_i;
    logic [PHYS_W-1:0]    commit_rd_phys_i;
    logic [PHYS_W-1:0]    commit_old_phys_i;
    logic                 commit_is_store_i;
    logic                 commit_branch_misp_i;
    logic [PC_W-1:0]      commit_branch_target_i;
    logic                 commit_ready_o;
    logic                 free_valid_o;
    logic [PHYS_W-1:0]    free_phys_o;
    logic                 store_commit_valid_o;
    logic [ROB_IDX_W-1:0] store_commit_idx_o;
    logic                 store_commit_ready_i;
    logic                 flush_o;
    logic                 redirect_valid_o;
    logic [PC_W-1:0]      redirect_pc_o;
    logic                 alloc_stall_o;
`ifdef ROB_COMMIT_PERF_EN
    logic [31:0] perf_commits_o, perf_flushes_o, perf_squashed_o;
`endif

    rob_commit_ctrl #(.RECOVER_CYCLES(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .commit_valid_i         (commit_valid_i),
        .commit_idx_i           (commit_idx_i),
        .commit_rd_phys_i       (commit_rd_phys_i),
        .commit_old_phys_i      (commit_old_phys_i),
        .commit_is_store_i      (commit_is_store_i),
        .commit_branch_misp_i   (commit_branch_misp_i),
        .commit_branch_target_i (commit_branch_target_i),
        .commit_ready_o         (commit_ready_o),
        .free_valid_o           (free_valid_o),
        .free_phys_o            (free_phys_o),
        .store_commit_valid_o   (store_commit_valid_o),
        .store_commit_idx_o     (store_commit_idx_o),
        .store_commit_ready_i   (store_commit_ready_i),
        .flush_o                (flush_o),
        .redirect_valid_o       (redirect_valid_o),
        .redirect_pc_o          (redirect_pc_o),
        .alloc_stall_o          (alloc_stall_o)
`ifdef ROB_COMMIT_PERF_EN
        ,
        .perf_commits_o         (perf_commits_o),
        .perf_flushes_o         (perf_flushes_o),
        .perf_squashed_o        (perf_squashed_o)
`endif
    );

    typedef struct {
        logic [ROB_IDX_W-1:0] idx;
        int                   len;
    } store_exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PHYS_W-1:0] exp_free[$];
    logic [PC_W-1:0]   exp_flush[$];
    store_exp_t        exp_store[$];
    int                exp_stall[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every emitted event against the head of its expectation queue.
    int                   st_run    = 0;
    logic [ROB_IDX_W-1:0] st_idx    = '0;
    int                   stall_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            st_run    = 0;
            stall_run = 0;
        end else begin
            if (free_valid_o) begin
                if (exp_free.size() == 0) check("free_unexpected", 64'(free_valid_o), 64'd0);
                else check("free_phys", 64'(free_phys_o), 64'(exp_free.pop_front()));
            end
            if (flush_o || redirect_valid_o) begin
                check("redirect_with_flush", 64'(redirect_valid_o), 64'(flush_o));
                if (exp_flush.size() == 0) check("flush_unexpected", 64'(flush_o), 64'd0);
                else check("redirect_pc", redirect_pc_o, exp_flush.pop_front());
                check("flush_not_during_store", 64'(store_commit_valid_o), 64'd0);
            end
            if (store_commit_valid_o) begin
                if (st_run > 0) check("store_idx_stable", 64'(store_commit_idx_o), 64'(st_idx));
                else check("ready_low_in_store_wait", 64'(commit_ready_o), 64'd0);
                st_idx = store_commit_idx_o;
                st_run++;
            end else if (st_run > 0) begin
                if (exp_store.size() == 0) begin
                    check("store_unexpected", 64'(st_run), 64'd0);
                end else begin
                    store_exp_t e;
                    e = exp_store.pop_front();
                    check("store_idx", 64'(st_idx), 64'(e.idx));
                    check("store_len", 64'(st_run), 64'(e.len));
                end
                st_run = 0;
            end
            if (alloc_stall_o) begin
                stall_run++;
            end else if (stall_run > 0) begin
                if (exp_stall.size() == 0) check("stall_unexpected", 64'(stall_run), 64'd0);
                else check("stall_len", 64'(stall_run), 64'(exp_stall.pop_front()));
                stall_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] idx, input logic [6:0] rd, input logic [6:0] old,
                         input logic st, input logic misp, input logic [63:0] tgt);
        commit_valid_i         = 1'b1;
        commit_idx_i           = idx;
        commit_rd_phys_i       = rd;
        commit_old_phys_i      = old;
        commit_is_store_i      = st;
        commit_branch_misp_i   = misp;
        commit_branch_target_i = tgt;
    endtask

    task automatic idle();
        commit_valid_i       = 1'b0;
        commit_is_store_i    = 1'b0;
        commit_branch_misp_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(commit_ready_o), 64'd1);
        check({tag, "_free_valid"}, 64'(free_valid_o), 64'd0);
        check({tag, "_free_phys"}, 64'(free_phys_o), 64'd0);
        check({tag, "_store_valid"}, 64'(store_commit_valid_o), 64'd0);
        check({tag, "_store_idx"}, 64'(store_commit_idx_o), 64'd0);
        check({tag, "_flush"}, 64'(flush_o), 64'd0);
        check({tag, "_redirect_valid"}, 64'(redirect_valid_o), 64'd0);
        check({tag, "_redirect_pc"}, redirect_pc_o, 64'd0);
        check({tag, "_stall"}, 64'(alloc_stall_o), 64'd0);
    endtask

    initial begin
        rst_n                = 1'b0;
        store_commit_ready_i = 1'b0;
        commit_idx_i         = '0;
        commit_rd_phys_i     = '0;
        commit_old_phys_i    = '0;
        commit_branch_target_i = '0;
        idle();
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Plain commit frees its old destination; ready stays high.
        exp_free.push_back(7'h12);
        drive(8'd5, 7'h30, 7'h12, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        check("plain_ready", 64'(commit_ready_o), 64'd1);
        tick();
        tick();

        // old_phys == 0 frees nothing (monitor flags any free).
        drive(8'd40, 7'h2F, 7'h00, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        check("zero_old_no_free", 64'(free_valid_o), 64'd0);
        tick();

        // Store with LSU ready held low for three cycles.
        exp_store.push_back('{idx: 8'd9, len: 4});
        drive(8'd9, 7'h31, 7'h00, 1'b1, 1'b0, 64'd0);
        tick();
        idle();
        repeat (3) tick();
        store_commit_ready_i = 1'b1;
        tick();
        store_commit_ready_i = 1'b0;
        check("store_back_to_run", 64'(commit_ready_o), 64'd1);
        check("store_released", 64'(store_commit_valid_o), 64'd0);
        tick();

        // Lagged commit during STORE_WAIT is buffered and processed after the handshake.
        exp_store.push_back('{idx: 8'd11, len: 2});
        exp_free.push_back(7'h13);
        exp_free.push_back(7'h15);
        drive(8'd11, 7'h32, 7'h13, 1'b1, 1'b0, 64'd0);
        tick();
        drive(8'd10, 7'h33, 7'h15, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        check("pending_blocks_ready", 64'(commit_ready_o), 64'd0);
        store_commit_ready_i = 1'b1;
        tick();
        store_commit_ready_i = 1'b0;
        tick();
        check("pending_drained_ready", 64'(commit_ready_o), 64'd1);
        tick();

        // Mispredict: single flush pulse and four stall cycles.
        exp_flush.push_back(64'h8000_1000);
        exp_stall.push_back(4);
        drive(8'd20, 7'h22, 7'h00, 1'b0, 1'b1, 64'h8000_1000);
        tick();
        idle();
        repeat (6) tick();

        // Commit one cycle after a mispredict is wrong-path: free rd_phys, no second flush.
        exp_free.push_back(7'h05);
        exp_flush.push_back(64'h4000_0040);
        exp_free.push_back(7'h21);
        exp_stall.push_back(4);
        drive(8'd21, 7'h23, 7'h05, 1'b0, 1'b1, 64'h4000_0040);
        tick();
        drive(8'd22, 7'h21, 7'h07, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        repeat (6) tick();
        check("redirect_pc_held", redirect_pc_o, 64'h4000_0040);
        check("redirect_valid_low", 64'(redirect_valid_o), 64'd0);

        // Mispredicted store: release first, then flush; the buffered younger entry is squashed.
        exp_free.push_back(7'h08);
        exp_store.push_back('{idx: 8'd30, len: 2});
        exp_flush.push_back(64'h0000_1234);
        exp_free.push_back(7'h0B);
        exp_stall.push_back(4);
        drive(8'd30, 7'h34, 7'h08, 1'b1, 1'b1, 64'h0000_1234);
        tick();
        drive(8'd31, 7'h0B, 7'h09, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        store_commit_ready_i = 1'b1;
        tick();
        store_commit_ready_i = 1'b0;
        repeat (7) tick();
        check("misp_store_back_to_run", 64'(commit_ready_o), 64'd1);

        // Reset in the middle of STORE_WAIT abandons the release.
        drive(8'd50, 7'h35, 7'h00, 1'b1, 1'b0, 64'd0);
        tick();
        idle();
        tick();
        check("store_wait_before_reset", 64'(store_commit_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        exp_free.push_back(7'h19);
        drive(8'd51, 7'h36, 7'h19, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        check("post_reset_ready", 64'(commit_ready_o), 64'd1);
        repeat (3) tick();

        check("free_queue_drained", 64'(exp_free.size()), 64'd0);
        check("flush_queue_drained", 64'(exp_flush.size()), 64'd0);
        check("store_queue_drained", 64'(exp_store.size()), 64'd0);
        check("stall_queue_drained", 64'(exp_stall.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
